// File: rtl/addsub_sched_pkg.sv
// Shared definitions for addsub_rr_scheduler: op encodings, round-robin
// pointer advance and the WIDTH+1 bit add/subtract used by the datapath.
package addsub_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the shared arithmetic helper supports.
  localparam int MAX_W = 64;

  // Pointer position just after the granted port, wrapping at n.
  function automatic int next_rr_ptr(input int g, input int n);
    return (g + 1) % n;
  endfunction

  // Add or subtract on MAX_W+1 bits. Callers truncate to WIDTH+1 bits.
  // Modular arithmetic makes the truncated top bit the carry (add) or
  // the borrow (subtract).
  function automatic logic [MAX_W:0] addsub_calc(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             cin,
    input logic             op
  );
    logic [MAX_W:0] ext_a;
    logic [MAX_W:0] ext_b;
    logic [MAX_W:0] ext_c;
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    ext_c = {{MAX_W{1'b0}}, cin};
    if (op == OP_SUB) begin
      return ext_a - ext_b - ext_c;
    end
    return ext_a + ext_b + ext_c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// scanning cyclically upward from ptr_i, as a one-hot grant and an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add/sub datapath among N_REQ requesters with round-robin
// arbitration and a single registered, ID-tagged result stage.
// Optional macro ADDSUB_SCHED_PRIO0_EN: requester 0 gets fixed priority and
// its grants leave the round-robin pointer untouched.
module addsub_rr_scheduler
  import addsub_sched_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic [N_REQ-1:0]       req_op,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_out,
  output logic                   res_cout,
  output logic [ID_W-1:0]        res_id
);

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_out_q, res_out_d;
  logic             res_cout_q, res_cout_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             xfer;
  logic [N_REQ-1:0] pick_gnt, sel_gnt;
  logic [ID_W-1:0]  pick_idx, sel_idx;
  logic             upd_ptr;
  logic [WIDTH:0]   calc;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign load_en = !res_valid_q || res_ready;

  // Final grant selection; port 0 may preempt the round-robin choice.
  always_comb begin
    sel_gnt = pick_gnt;
    sel_idx = pick_idx;
    upd_ptr = 1'b1;
`ifdef ADDSUB_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      sel_gnt    = '0;
      sel_gnt[0] = 1'b1;
      sel_idx    = '0;
      upd_ptr    = 1'b0;
    end
`endif
  end

  assign req_ready = (RST || !load_en) ? '0 : sel_gnt;
  // req_ready only ever selects a valid port, so any ready bit is a transfer.
  assign xfer      = |req_ready;

  assign calc = (WIDTH + 1)'(addsub_calc(MAX_W'(a_arr[sel_idx]),
                                         MAX_W'(b_arr[sel_idx]),
                                         req_cin[sel_idx],
                                         req_op[sel_idx]));

  // Next state of the result stage and the round-robin pointer.
  always_comb begin
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_out_d   = calc[WIDTH-1:0];
      res_cout_d  = calc[WIDTH];
      res_id_d    = sel_idx;
      if (upd_ptr) begin
        rr_ptr_d = ID_W'(next_rr_ptr(int'(sel_idx), N_REQ));
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one pre-adder/subtractor datapath (W-bit add/sub with carry-in and carry-out, op select equivalent to OPMODE[6]) among N requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- One registered result stage with backpressure; every result is tagged with the ID of the requester it belongs to.
- Sits between DSP48A1 operand sources (pre-adder feeders) and downstream multiplier/post-adder consumers.

Parameters:
- WIDTH, 18, operand and result width in bits.
- N_REQ, 4, number of requesters; must be ≥ 1.
- ID_W, $clog2(N_REQ) with a minimum of 1, width of res_id.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*WIDTH  packed first operand; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed second operand; same packing.
- req_cin  in  N_REQ  per-requester carry-in.
- req_op  in  N_REQ  0 = add (a+b+cin), 1 = subtract (a−b−cin).
- res_valid  out  1  result register holds valid data.
- res_ready  in  1  downstream accepts the result.
- res_out  out  WIDTH  registered result.
- res_cout  out  1  registered carry (add) or borrow (subtract).
- res_id  out  ID_W  index of the requester that produced res_out.

Behaviour:
- Reset: a synchronous reset must produce these values on the next edge:
  - res_valid=0, res_out=0, res_cout=0, res_id=0, rr_ptr=0.
  - req_ready is forced to 0 combinationally while RST=1.
- load_en = !res_valid || res_ready. The result register may be loaded this cycle only when load_en=1.
- Grant: when load_en=1 and any req_valid is set, g = the first set req_valid found scanning cyclically from rr_ptr. Assert req_ready[g]=1 in that cycle only. All other req_ready bits are 0. With no valid request, or with load_en=0, all req_ready bits are 0.
- A transfer on port g occurs when req_valid[g] && req_ready[g]. On that edge:
  - res_out and res_cout load from the arithmetic rule below.
  - res_id <= g; res_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
- Arithmetic, on WIDTH+1 bits:
  - op=0: {cout,out} = a + b + cin.
  - op=1: {cout,out} = a − b − cin (two's complement wrap). cout=1 means borrow.
- Latency and throughput: a result appears 1 cycle after the transfer. One result per cycle is sustained when res_ready=1.
- Hold: if res_valid=1 and res_ready=0, res_out, res_cout and res_id stay stable and rr_ptr does not change.
- Drain: if res_valid=1, res_ready=1 and no transfer occurs, res_valid <= 0 on the next edge.
- Simultaneous consume and grant in the same cycle: the new result replaces the old one with no bubble.
- req_valid must be held by the requester until req_ready; the scheduler does not drop or retain requests internally.
- Reset mid-operation: any held result is discarded and the pointer returns to 0.
- N_REQ=1: rr_ptr is fixed at 0; only the handshake logic remains.

Optional Feature:
- ADDSUB_SCHED_PRIO0_EN.
- Defined: requester 0 has fixed priority. If req_valid[0]=1 and load_en=1, port 0 is granted regardless of rr_ptr, and rr_ptr is not updated. Remaining ports are served round-robin when port 0 is idle.
- Undefined: pure round-robin as above.

Decomposition:
- Package addsub_sched_pkg holds:
  - localparams OP_ADD=1'b0 and OP_SUB=1'b1;
  - a function computing the next rr pointer;
  - a function performing the WIDTH+1 add/sub.
- Sub-module rr_pick: a combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and binary index. The top level holds the pointer, the result register and the handshake.

Test Plan:
- Add: requester 2 only, a=5, b=7, cin=1, op=0, res_ready=1 → next cycle res_valid=1, res_out=13, res_cout=0, res_id=2.
- Subtract with borrow: a=3, b=5, cin=0, op=1 → res_out=0x3FFFE, res_cout=1. Add overflow: a=0x3FFFF, b=1, cin=0, op=0 → res_out=0, res_cout=1.
- Fairness: all four req_valid held at 1, res_ready=1 → res_id sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one req_ready high per cycle.
- Backpressure: hold res_ready=0 for 3 cycles while res_valid=1 → res_out, res_cout and res_id stable and req_ready=0. Raise res_ready → a grant issues that same cycle and the new result follows with no bubble.
- Reset mid-operation: assert RST for 1 cycle while res_valid=1 and rr_ptr=2 → res_valid=0 next edge and req_ready=0 during reset. With all requests valid afterwards, the first grant goes to port 0.
- With ADDSUB_SCHED_PRIO0_EN defined and all ports valid → port 0 is granted every cycle. With port 0 dropped → ports 1,2,3 rotate.
